load_store_unit: RTL and testbench

Sits between the core's execute stage and the MMIO data bus that the memory and peripheral blocks decode. It accepts byte, halfword and word loads and stores from the core and issues word-aligned bus accesses. Sub-word stores are done as read-modify-write, because devices on the bus only accept whole-word writes. Loaded data is lane-extracted and sign- or zero-extended, and misaligned or unmapped accesses are reported as faults.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and address helpers for the load/store unit.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_ACCESS   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_e;

   // Size 11 behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_WORD : size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lsb[0];
         default: return (lsb != 2'b00);
      endcase
   endfunction

   function automatic logic [XLEN-1:0] natural_align(input logic [1:0] size,
                                                     input logic [XLEN-1:0] addr);
      case (size)
         SZ_BYTE: return addr;
         SZ_HALF: return {addr[XLEN-1:1], 1'b0};
         default: return {addr[XLEN-1:2], 2'b00};
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract with sign/zero extension, and
// sub-word store merge into the read word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] i_word,
   input  logic [1:0]      i_addr,
   input  logic [1:0]      i_size,
   input  logic            i_unsigned,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rdata,
   output logic [XLEN-1:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_word[{i_addr, 3'b000} +: 8];
      w_half   = i_word[{i_addr[1], 4'b0000} +: 16];
      o_rdata  = i_word;
      o_merged = i_word;
      case (i_size)
         SZ_BYTE: begin
            o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
         end
         SZ_HALF: begin
            o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
            o_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: begin
            o_rdata  = i_word;
            o_merged = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging the core to the word-only MMIO bus (RMW for sub-word stores).
// Define LSU_MISALIGN_CHECK_EN to fault misaligned requests; otherwise they are force-aligned.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic [1:0]      resp_fault,
   output logic [XLEN-1:0] bus_address,
   input  logic [XLEN-1:0] bus_read_data,
   output logic [XLEN-1:0] bus_write_data,
   output logic            bus_write_sig,
   input  logic            bus_selected
);

   lsu_state_e       r_state;
   lsu_state_e       w_state_next;
   logic [XLEN-1:0]  r_addr;
   logic [1:0]       r_size;
   logic             r_write;
   logic             r_unsigned;
   logic [XLEN-1:0]  r_wdata;
   logic [XLEN-1:0]  r_rdata;
   logic [1:0]       r_fault;

   logic [1:0]       w_req_size;
   logic [XLEN-1:0]  w_req_addr;
   logic             w_misalign;
   logic [XLEN-1:0]  w_extract;
   logic [XLEN-1:0]  w_merged;

   assign w_req_size = norm_size(req_size);

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_req_addr = req_addr;
   assign w_misalign = is_misaligned(w_req_size, req_addr[1:0]);
`else
   assign w_req_addr = natural_align(w_req_size, req_addr);
   assign w_misalign = 1'b0;
`endif

   lsu_lane_align u_lane_align (
      .i_word     (bus_read_data),
      .i_addr     (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_wdata    (r_wdata),
      .o_rdata    (w_extract),
      .o_merged   (w_merged)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state and bus/handshake decode from registered state only.
   always_comb begin
      w_state_next   = r_state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      bus_address    = '0;
      bus_write_data = '0;
      bus_write_sig  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_misalign)                 w_state_next = ST_RESP;
               else if (!req_write)            w_state_next = ST_RD;
               else if (w_req_size == SZ_WORD) w_state_next = ST_WR;
               else                            w_state_next = ST_RD;
            end
         end
         ST_RD: begin
            bus_address  = {r_addr[XLEN-1:2], 2'b00};
            w_state_next = (!bus_selected || !r_write) ? ST_RESP : ST_WR;
         end
         ST_WR: begin
            bus_address    = {r_addr[XLEN-1:2], 2'b00};
            bus_write_data = r_wdata;
            bus_write_sig  = !rst;
            w_state_next   = ST_RESP;
         end
         ST_RESP: begin
            resp_valid   = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request capture and result registers; r_wdata holds the merged word after RD.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_size     <= SZ_BYTE;
         r_write    <= 1'b0;
         r_unsigned <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_fault    <= FLT_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_addr     <= w_req_addr;
                  r_size     <= w_req_size;
                  r_write    <= req_write;
                  r_unsigned <= req_unsigned;
                  r_wdata    <= req_wdata;
                  r_rdata    <= '0;
                  r_fault    <= w_misalign ? FLT_MISALIGN : FLT_NONE;
               end
            end
            ST_RD: begin
               if (!bus_selected) r_fault <= FLT_ACCESS;
               else if (!r_write) r_rdata <= w_extract;
               else               r_wdata <= w_merged;
            end
            ST_WR: begin
               if (!bus_selected) r_fault <= FLT_ACCESS;
            end
            default: ;
         endcase
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word memory at 0x90000000.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_fault;
   logic [31:0] bus_address;
   logic [31:0] bus_read_data;
   logic [31:0] bus_write_data;
   logic        bus_write_sig;
   logic        bus_selected;

   load_store_unit dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .bus_address    (bus_address),
      .bus_read_data  (bus_read_data),
      .bus_write_data (bus_write_data),
      .bus_write_sig  (bus_write_sig),
      .bus_selected   (bus_selected)
   );

   always #5 clk = ~clk;

   // Memory device; pokes give the bench a backdoor preload.
   logic [31:0] mem [0:15];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;

   assign bus_selected  = (bus_address[31:6] == 26'h2400000);
   assign bus_read_data = bus_selected ? mem[bus_address[5:2]] : 32'hDEADBEEF;

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      else if (bus_write_sig && bus_selected) mem[bus_address[5:2]] <= bus_write_data;
   end

   int n_checks = 0;
   int n_pass   = 0;

   int          lat;
   int          wr_pulses;
   logic [31:0] wr_data;
   logic [31:0] rd;
   logic [1:0]  flt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic poke(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      poke_en = 1'b1; poke_idx = idx; poke_val = val;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Issue one request; lat = cycles after the acceptance edge until resp_valid.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
      logic got_valid;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; wr_pulses = 0; wr_data = '0; rd = '0; flt = '0; got_valid = 1'b0;
      while (lat < 10 && !got_valid) begin
         @(negedge clk);
         if (bus_write_sig) begin
            wr_pulses++;
            wr_data = bus_write_data;
         end
         if (resp_valid) begin
            got_valid = 1'b1;
            rd  = resp_rdata;
            flt = resp_fault;
         end else lat++;
      end
      if (!got_valid) chk("resp_timeout", 32'(lat), 32'(0));
   endtask

   task automatic load_chk(input string tag, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] exp);
      do_req(1'b0, sz, u, a, 32'h0);
      chk({tag, "_rdata"}, rd, exp);
      chk({tag, "_fault"}, 32'(flt), 32'(0));
   endtask

   initial begin
      logic        seen;
      int          t, acc1, acc2, resp1, resp2;
      logic [31:0] d1, d2;

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'(1));
      chk("rst_resp_valid", 32'(resp_valid), 32'(0));
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_fault", 32'(resp_fault), 32'(0));
      chk("rst_bus_addr", bus_address, 32'h0);
      chk("rst_bus_wdata", bus_write_data, 32'h0);
      chk("rst_bus_wsig", 32'(bus_write_sig), 32'(0));
      rst = 1'b0;

      // Byte and half loads with sign/zero extension.
      poke(4'd1, 32'h80FF7F01);
      do_req(1'b0, 2'b00, 1'b0, 32'h90000006, 32'h0);
      chk("lb_rdata", rd, 32'hFFFFFFFF);
      chk("lb_fault", 32'(flt), 32'(0));
      chk("lb_latency", 32'(lat), 32'(1));
      load_chk("lbu", 2'b00, 1'b1, 32'h90000007, 32'h00000080);
      load_chk("lb0", 2'b00, 1'b0, 32'h90000004, 32'h00000001);
      load_chk("lh_lo", 2'b01, 1'b0, 32'h90000004, 32'h00007F01);
      load_chk("lh_hi", 2'b01, 1'b0, 32'h90000006, 32'hFFFF80FF);
      load_chk("lhu_hi", 2'b01, 1'b1, 32'h90000006, 32'h000080FF);
      load_chk("lw", 2'b10, 1'b0, 32'h90000004, 32'h80FF7F01);
      load_chk("lw_sz3", 2'b11, 1'b0, 32'h90000004, 32'h80FF7F01);

      // Sub-word stores by read-modify-write, word store direct.
      poke(4'd0, 32'h11223344);
      do_req(1'b1, 2'b01, 1'b0, 32'h90000002, 32'h1234ABCD);
      chk("sh_pulses", 32'(wr_pulses), 32'(1));
      chk("sh_wdata", wr_data, 32'hABCD3344);
      chk("sh_latency", 32'(lat), 32'(2));
      chk("sh_rdata", rd, 32'h0);
      chk("sh_fault", 32'(flt), 32'(0));
      load_chk("lw_after_sh", 2'b10, 1'b0, 32'h90000000, 32'hABCD3344);
      do_req(1'b1, 2'b00, 1'b0, 32'h90000001, 32'h00000055);
      chk("sb_wdata", wr_data, 32'hABCD5544);
      chk("sb_latency", 32'(lat), 32'(2));
      chk("sb_mem", mem[0], 32'hABCD5544);
      do_req(1'b1, 2'b10, 1'b0, 32'h90000008, 32'hCAFEF00D);
      chk("sw_latency", 32'(lat), 32'(1));
      chk("sw_pulses", 32'(wr_pulses), 32'(1));
      chk("sw_mem", mem[2], 32'hCAFEF00D);

      // Misaligned requests: fault, or forced alignment when checking is off.
      do_req(1'b1, 2'b10, 1'b0, 32'h90000001, 32'h12345678);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("mis_sw_fault", 32'(flt), 32'(1));
      chk("mis_sw_latency", 32'(lat), 32'(0));
      chk("mis_sw_pulses", 32'(wr_pulses), 32'(0));
      chk("mis_sw_mem", mem[0], 32'hABCD5544);
`else
      chk("mis_sw_fault", 32'(flt), 32'(0));
      chk("mis_sw_latency", 32'(lat), 32'(1));
      chk("mis_sw_pulses", 32'(wr_pulses), 32'(1));
      chk("mis_sw_mem", mem[0], 32'h12345678);
`endif
      do_req(1'b0, 2'b01, 1'b0, 32'h90000005, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("mis_lh_fault", 32'(flt), 32'(1));
      chk("mis_lh_rdata", rd, 32'h0);
`else
      chk("mis_lh_fault", 32'(flt), 32'(0));
      chk("mis_lh_rdata", rd, 32'h00007F01);
`endif

      // Unmapped accesses.
      do_req(1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0);
      chk("unm_lw_fault", 32'(flt), 32'(2));
      chk("unm_lw_rdata", rd, 32'h0);
      chk("unm_lw_latency", 32'(lat), 32'(1));
      do_req(1'b1, 2'b00, 1'b0, 32'h80000000, 32'h000000AA);
      chk("unm_sb_fault", 32'(flt), 32'(2));
      chk("unm_sb_pulses", 32'(wr_pulses), 32'(0));

      // Reset asserted during the WR cycle of a byte store.
      poke(4'd3, 32'h01020304);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h9000000C; req_wdata = 32'h000000EE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstwr_bus_addr", bus_address, 32'h9000000C);
      rst = 1'b1;
      #1 chk("rstwr_wsig", 32'(bus_write_sig), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      chk("rstwr_idle", 32'(req_ready), 32'(1));
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("rstwr_no_resp", 32'(seen), 32'(0));
      chk("rstwr_mem", mem[3], 32'h01020304);

      // Back-to-back loads with req_valid held high.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h90000004;
      acc1 = -1; acc2 = -1; resp1 = -1; resp2 = -1; d1 = '0; d2 = '0;
      for (t = 0; t < 15 && resp2 < 0; t++) begin
         if (resp_valid) begin
            if (resp1 < 0) begin resp1 = t; d1 = resp_rdata; end
            else begin resp2 = t; d2 = resp_rdata; end
         end
         if (acc1 >= 0 && acc2 < 0 && t == acc1 + 1) begin
            chk("b2b_busy", 32'(req_ready), 32'(0));
            req_addr = 32'h90000008;
         end
         if (req_ready && req_valid) begin
            if (acc1 < 0) acc1 = t;
            else begin acc2 = t; end
         end
         @(negedge clk);
         if (acc2 >= 0) req_valid = 1'b0;
      end
      chk("b2b_first_resp", 32'(resp1 - acc1), 32'(2));
      chk("b2b_gap", 32'(acc2 - resp1), 32'(1));
      chk("b2b_second_resp", 32'(resp2 - acc2), 32'(2));
      chk("b2b_d1", d1, 32'h80FF7F01);
      chk("b2b_d2", d2, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
